// File: rtl/hog_pkg.sv
// Shared definitions for the streaming HOG block normaliser.
// Provides the width helpers, norm-mode constants and the controller state type.
package hog_pkg;

  localparam int unsigned MODE_L2 = 0;
  localparam int unsigned MODE_L1 = 1;

  typedef enum logic [1:0] {LOAD, NORM, DIV, OUT} state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Accumulator holds the sum of n squared in_w-bit values without overflow.
  function automatic int unsigned acc_w(input int unsigned in_w, input int unsigned n);
    return 2 * in_w + clog2(n);
  endfunction

  // Dividend is the bin value pre-shifted into the Q1.(out_w-1) output scale.
  function automatic int unsigned num_w(input int unsigned in_w, input int unsigned out_w);
    return in_w + out_w - 1;
  endfunction

  function automatic int unsigned den_w(input int unsigned in_w, input int unsigned n);
    return acc_w(in_w, n);
  endfunction

endpackage

// File: rtl/hog_div_seq.sv
// Restoring unsigned sequential divider, one quotient bit per cycle.
// Ports: iClk/iRst (async high), iStart loads iNum/iDen; oQuot valid when
// oDone pulses, NUM_W cycles after iStart; oBusy high while iterating.
module hog_div_seq
  import hog_pkg::*;
#(
  parameter int unsigned NUM_W = 31,
  parameter int unsigned DEN_W = 38
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [NUM_W-1:0] iNum,
  input  logic [DEN_W-1:0] iDen,
  output logic [NUM_W-1:0] oQuot,
  output logic             oBusy,
  output logic             oDone
);

  localparam int unsigned CNT_W = clog2(NUM_W + 1);

  logic [DEN_W-1:0] rem;
  logic [DEN_W-1:0] den_r;
  logic [CNT_W-1:0] cnt;
  logic [DEN_W:0]   trial_c;
  logic             ge_c;
  logic [DEN_W-1:0] diff_c;

  // oQuot doubles as the dividend shift register; quotient bits enter at the LSB.
  assign trial_c = {rem, oQuot[NUM_W-1]};
  assign ge_c    = trial_c >= {1'b0, den_r};
  assign diff_c  = trial_c[DEN_W-1:0] - den_r;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      rem   <= '0;
      den_r <= '0;
      cnt   <= '0;
      oQuot <= '0;
      oBusy <= 1'b0;
      oDone <= 1'b0;
    end else begin
      oDone <= 1'b0;
      if (iStart) begin
        rem   <= '0;
        den_r <= iDen;
        oQuot <= iNum;
        cnt   <= CNT_W'(NUM_W);
        oBusy <= 1'b1;
      end else if (oBusy) begin
        rem   <= ge_c ? diff_c : trial_c[DEN_W-1:0];
        oQuot <= {oQuot[NUM_W-2:0], ge_c};
        cnt   <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          oBusy <= 1'b0;
          oDone <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hog_block_norm_stream.sv
// Streaming HOG block normaliser: buffers N_CELLS*N_BINS bins, computes the
// L2 (integer sqrt) or L1 block norm, then streams each bin / norm in
// Q1.(OUT_W-1), saturated and clipped to CLIP.
// Ports: iClk, iRst (async high); input stream iValid/iFirst/iData with
// oInReady; output stream oValid/oData/oLast with iOutReady; oDONE pulses
// after the final output is taken; oSyncErr pulses when a partial block is
// dropped on an early iFirst.
module hog_block_norm_stream
  import hog_pkg::*;
#(
  parameter int unsigned N_CELLS = 4,
  parameter int unsigned N_BINS  = 9,
  parameter int unsigned IN_W    = 16,
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned MODE    = 0,
  parameter int unsigned EPS     = 1,
  parameter int unsigned CLIP    = (32'd1 << OUT_W) - 32'd1
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  input  logic             iFirst,
  input  logic [IN_W-1:0]  iData,
  output logic             oInReady,
  output logic             oValid,
  output logic [OUT_W-1:0] oData,
  output logic             oLast,
  input  logic             iOutReady,
  output logic             oDONE,
  output logic             oSyncErr
);

  localparam int unsigned N     = N_CELLS * N_BINS;
  localparam int unsigned ACC_W = acc_w(IN_W, N);
  localparam int unsigned NUM_W = num_w(IN_W, OUT_W);
  localparam int unsigned DEN_W = den_w(IN_W, N);
  localparam int unsigned SQ_W  = (ACC_W + 1) / 2;
  localparam int unsigned RAD_W = 2 * SQ_W;
  localparam int unsigned R_W   = SQ_W + 4;
  localparam int unsigned SQC_W = clog2(SQ_W + 1);
  localparam int unsigned IDX_W = clog2(N + 1);
  localparam int unsigned QMAX  = (32'd1 << OUT_W) - 32'd1;

  state_t state, next_state;

  logic [IN_W-1:0]  bin_mem [N];
  logic [IDX_W-1:0] count, idx;
  logic [ACC_W-1:0] acc;
  logic [RAD_W-1:0] rad;
  logic signed [R_W-1:0] sq_r;
  logic [SQ_W-1:0]  sq_q;
  logic [SQC_W-1:0] sq_cnt;
  logic [DEN_W-1:0] den;
  logic [OUT_W-1:0] data_q;
  logic             last_q, valid_q, in_ready_q, done_q, sync_q;

  logic [NUM_W-1:0] div_quot;
  logic             div_busy, div_done;

  logic             accept_c, resync_c, last_in_c, out_fire_c, last_out_c, div_start_c;
  logic [IDX_W-1:0] widx_c;
  logic [ACC_W-1:0] term_c, acc_next_c;
  logic signed [R_W-1:0] sq_sh_c, sq_sub_c, sq_add_c, sq_r_n_c;
  logic [SQ_W-1:0]  sq_q_n_c;
  logic [OUT_W-1:0] q_sat_c, q_clip_c;

  // Input side: an early iFirst restarts the block at index 0.
  assign accept_c   = (state == LOAD) && iValid;
  assign resync_c   = accept_c && iFirst && (count != '0);
  assign widx_c     = resync_c ? '0 : count;
  assign term_c     = (MODE == MODE_L1) ? ACC_W'(iData) : ACC_W'(iData) * ACC_W'(iData);
  assign acc_next_c = (resync_c ? '0 : acc) + term_c;
  assign last_in_c  = accept_c && (widx_c == IDX_W'(N - 1));

  assign out_fire_c  = (state == OUT) && iOutReady;
  assign last_out_c  = (idx == IDX_W'(N - 1));
  assign div_start_c = (state == DIV) && !div_busy && !div_done;

  // Non-restoring sqrt step: sign of the partial remainder picks add or subtract.
  assign sq_sh_c  = (sq_r <<< 2) | $signed({{(R_W-2){1'b0}}, rad[RAD_W-1 -: 2]});
  assign sq_sub_c = $signed(R_W'({sq_q, 2'b01}));
  assign sq_add_c = $signed(R_W'({sq_q, 2'b11}));
  assign sq_r_n_c = sq_r[R_W-1] ? (sq_sh_c + sq_add_c) : (sq_sh_c - sq_sub_c);
  assign sq_q_n_c = {sq_q[SQ_W-2:0], ~sq_r_n_c[R_W-1]};

  assign q_sat_c  = (div_quot > NUM_W'(QMAX)) ? OUT_W'(QMAX) : div_quot[OUT_W-1:0];
  assign q_clip_c = (q_sat_c > OUT_W'(CLIP)) ? OUT_W'(CLIP) : q_sat_c;

  hog_div_seq #(
    .NUM_W(NUM_W),
    .DEN_W(DEN_W)
  ) u_div (
    .iClk  (iClk),
    .iRst  (iRst),
    .iStart(div_start_c),
    .iNum  ({bin_mem[idx], (OUT_W-1)'(0)}),
    .iDen  (den),
    .oQuot (div_quot),
    .oBusy (div_busy),
    .oDone (div_done)
  );

  // State register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= LOAD;
    else      state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      LOAD: if (last_in_c) next_state = NORM;
      NORM: if ((MODE == MODE_L1) || (sq_cnt == SQC_W'(1))) next_state = DIV;
      DIV:  if (div_done) next_state = OUT;
      OUT:  if (iOutReady) next_state = last_out_c ? LOAD : DIV;
      default: next_state = LOAD;
    endcase
  end

  // Bin buffer; contents are don't-care after reset.
  always_ff @(posedge iClk) begin
    if (accept_c) bin_mem[widx_c] <= iData;
  end

  // Datapath and registered outputs.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      count      <= '0;
      idx        <= '0;
      acc        <= '0;
      rad        <= '0;
      sq_r       <= '0;
      sq_q       <= '0;
      sq_cnt     <= '0;
      den        <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
      in_ready_q <= 1'b1;
      done_q     <= 1'b0;
      sync_q     <= 1'b0;
    end else begin
      valid_q    <= (next_state == OUT);
      in_ready_q <= (next_state == LOAD);
      done_q     <= out_fire_c && last_out_c;
      sync_q     <= resync_c;
      case (state)
        LOAD: begin
          if (accept_c) begin
            acc   <= acc_next_c;
            count <= widx_c + IDX_W'(1);
          end
          if (last_in_c) begin
            rad    <= RAD_W'(acc_next_c) + RAD_W'(EPS);
            sq_r   <= '0;
            sq_q   <= '0;
            sq_cnt <= SQC_W'(SQ_W);
          end
        end
        NORM: begin
          if (MODE == MODE_L1) begin
            den <= DEN_W'(acc) + DEN_W'(EPS);
          end else begin
            rad    <= {rad[RAD_W-3:0], 2'b00};
            sq_r   <= sq_r_n_c;
            sq_q   <= sq_q_n_c;
            sq_cnt <= sq_cnt - SQC_W'(1);
            if (sq_cnt == SQC_W'(1)) den <= DEN_W'(sq_q_n_c);
          end
        end
        DIV: begin
          if (div_done) begin
            data_q <= q_clip_c;
            last_q <= last_out_c;
          end
        end
        OUT: begin
          if (out_fire_c) begin
            last_q <= 1'b0;
            if (last_out_c) begin
              idx   <= '0;
              count <= '0;
              acc   <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign oInReady = in_ready_q;
  assign oValid   = valid_q;
  assign oData    = data_q;
  assign oLast    = last_q;
  assign oDONE    = done_q;
  assign oSyncErr = sync_q;

endmodule

// File: tb/tb_hog_block_norm_stream.sv
// Directed bench for hog_block_norm_stream: three instances (L2 default,
// L1, L2 with CLIP=6554) share the input stream and output ready.
module tb_hog_block_norm_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_first, out_ready;
  logic [15:0] in_data;
  logic [2:0]  in_rdy, ov, ol, dn, se;
  logic [15:0] od [3];

  int checks = 0;
  int errors = 0;

  logic [15:0] stim [36];
  logic [15:0] cap [3][36];
  int          ncap [3];
  int          nlast [3];
  int          last_idx [3];
  int          ndone [3];
  int          nsync [3];
  int          hold_err [3];
  int          xcnt [3];
  logic        stalled [3];
  logic [15:0] hold_d [3];
  logic        mon_clr;

  hog_block_norm_stream u_l2 (
    .iClk(clk), .iRst(rst), .iValid(in_valid), .iFirst(in_first), .iData(in_data),
    .oInReady(in_rdy[0]), .oValid(ov[0]), .oData(od[0]), .oLast(ol[0]),
    .iOutReady(out_ready), .oDONE(dn[0]), .oSyncErr(se[0])
  );

  hog_block_norm_stream #(.MODE(1)) u_l1 (
    .iClk(clk), .iRst(rst), .iValid(in_valid), .iFirst(in_first), .iData(in_data),
    .oInReady(in_rdy[1]), .oValid(ov[1]), .oData(od[1]), .oLast(ol[1]),
    .iOutReady(out_ready), .oDONE(dn[1]), .oSyncErr(se[1])
  );

  hog_block_norm_stream #(.CLIP(6554)) u_clip (
    .iClk(clk), .iRst(rst), .iValid(in_valid), .iFirst(in_first), .iData(in_data),
    .oInReady(in_rdy[2]), .oValid(ov[2]), .oData(od[2]), .oLast(ol[2]),
    .iOutReady(out_ready), .oDONE(dn[2]), .oSyncErr(se[2])
  );

  // Output monitor: records transfers, pulses, X values and stall stability.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (mon_clr) begin
        ncap[k] = 0; nlast[k] = 0; last_idx[k] = -1; ndone[k] = 0; nsync[k] = 0;
        hold_err[k] = 0; xcnt[k] = 0; stalled[k] = 1'b0; hold_d[k] = '0;
      end else begin
        if ($isunknown(od[k]) || $isunknown(ov[k])) xcnt[k]++;
        if (stalled[k] && (ov[k] !== 1'b1 || od[k] !== hold_d[k])) hold_err[k]++;
        stalled[k] = ov[k] && !out_ready;
        hold_d[k] = od[k];
        if (ov[k] && out_ready) begin
          if (ncap[k] < 36) cap[k][ncap[k]] = od[k];
          if (ol[k]) begin nlast[k]++; last_idx[k] = ncap[k]; end
          ncap[k]++;
        end
        if (dn[k]) ndone[k]++;
        if (se[k]) nsync[k]++;
      end
    end
  end

  task automatic clear_mon;
    mon_clr = 1'b1;
    @(negedge clk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic drive(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_first = (j == 0);
      in_data  = stim[j];
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    int cyc;
    cyc = 0;
    while (!((ncap[0] >= 36) && (ncap[1] >= 36) && (ncap[2] >= 36) && (in_rdy === 3'b111))
           && cyc < 8000) begin
      @(posedge clk); #1;
      cyc++;
    end
    ok = (cyc < 8000);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++; if (in_rdy !== 3'b111) begin errors++; $display("FAIL reset_in_ready got %b expected 111", in_rdy); end
    checks++; if (ov !== 3'b000) begin errors++; $display("FAIL reset_valid got %b expected 000", ov); end
    checks++; if ((dn | se | ol) !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b/%b/%b expected 0", dn, se, ol); end
    checks++; if (od[0] !== 16'd0) begin errors++; $display("FAIL reset_data got %0d expected 0", od[0]); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_rdy !== 3'b111 || ov !== 3'b000) begin
      errors++; $display("FAIL post_reset_idle got rdy=%b valid=%b expected 111/000", in_rdy, ov);
    end
  endtask

  task automatic test_l2_uniform;
    bit ok;
    for (int j = 0; j < 36; j++) stim[j] = 16'd100;
    clear_mon; drive(36); wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL uniform_timeout got ncap=%0d/%0d/%0d expected 36", ncap[0], ncap[1], ncap[2]); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (ncap[k] !== 36) begin errors++; $display("FAIL uniform_count[%0d] got %0d expected 36", k, ncap[k]); end
    end
    for (int j = 0; j < 36; j++) begin
      checks++; if (cap[0][j] !== 16'd5461) begin errors++; $display("FAIL uniform_l2[%0d] got %0d expected 5461", j, cap[0][j]); end
      checks++; if (cap[1][j] !== 16'd909) begin errors++; $display("FAIL uniform_l1[%0d] got %0d expected 909", j, cap[1][j]); end
      checks++; if (cap[2][j] !== 16'd5461) begin errors++; $display("FAIL uniform_clip[%0d] got %0d expected 5461", j, cap[2][j]); end
    end
    checks++; if (nlast[0] !== 1 || last_idx[0] !== 35) begin errors++; $display("FAIL uniform_last got n=%0d at %0d expected 1 at 35", nlast[0], last_idx[0]); end
    checks++; if (ndone[0] !== 1 || ndone[1] !== 1) begin errors++; $display("FAIL uniform_done got %0d/%0d expected 1/1", ndone[0], ndone[1]); end
    checks++; if (nsync[0] !== 0) begin errors++; $display("FAIL uniform_sync got %0d expected 0", nsync[0]); end
  endtask

  task automatic test_single_peak;
    bit ok;
    logic [15:0] e0, e1, e2;
    for (int j = 0; j < 36; j++) stim[j] = (j == 0) ? 16'd1000 : 16'd0;
    clear_mon; drive(36); wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL peak_timeout got ncap=%0d expected 36", ncap[0]); end
    for (int j = 0; j < 36; j++) begin
      e0 = (j == 0) ? 16'd32768 : 16'd0;
      e1 = (j == 0) ? 16'd32735 : 16'd0;
      e2 = (j == 0) ? 16'd6554  : 16'd0;
      checks++; if (cap[0][j] !== e0) begin errors++; $display("FAIL peak_l2[%0d] got %0d expected %0d", j, cap[0][j], e0); end
      checks++; if (cap[1][j] !== e1) begin errors++; $display("FAIL peak_l1[%0d] got %0d expected %0d", j, cap[1][j], e1); end
      checks++; if (cap[2][j] !== e2) begin errors++; $display("FAIL peak_clip[%0d] got %0d expected %0d", j, cap[2][j], e2); end
    end
  endtask

  task automatic test_all_zero;
    bit ok;
    for (int j = 0; j < 36; j++) stim[j] = 16'd0;
    clear_mon; drive(36); wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero_timeout got ncap=%0d expected 36", ncap[0]); end
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 36; j++) begin
        checks++; if (cap[k][j] !== 16'd0) begin errors++; $display("FAIL zero_data[%0d][%0d] got %0d expected 0", k, j, cap[k][j]); end
      end
      checks++; if (xcnt[k] !== 0) begin errors++; $display("FAIL zero_x[%0d] got %0d expected 0", k, xcnt[k]); end
      checks++; if (ndone[k] !== 1) begin errors++; $display("FAIL zero_done[%0d] got %0d expected 1", k, ndone[k]); end
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    int cyc;
    logic [15:0] e0, e1, e2;
    for (int j = 0; j < 36; j++) stim[j] = (j % 2 == 0) ? 16'd100 : 16'd200;
    clear_mon; drive(36);
    cyc = 0;
    while (!(ncap[0] == 5 && ov[0] === 1'b1) && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (cyc >= 4000) begin errors++; $display("FAIL bp_reach_elem5 got ncap=%0d expected 5 with valid", ncap[0]); end
    out_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (ncap[0] !== 5 || ov[0] !== 1'b1) begin errors++; $display("FAIL bp_stall got ncap=%0d valid=%b expected 5/1", ncap[0], ov[0]); end
    out_ready = 1'b1;
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got ncap=%0d expected 36", ncap[0]); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (hold_err[k] !== 0) begin errors++; $display("FAIL bp_hold[%0d] got %0d expected 0", k, hold_err[k]); end
      checks++; if (ncap[k] !== 36) begin errors++; $display("FAIL bp_count[%0d] got %0d expected 36", k, ncap[k]); end
    end
    for (int j = 0; j < 36; j++) begin
      e0 = (j % 2 == 0) ? 16'd3456 : 16'd6913;
      e1 = (j % 2 == 0) ? 16'd606  : 16'd1213;
      e2 = (j % 2 == 0) ? 16'd3456 : 16'd6554;
      checks++; if (cap[0][j] !== e0) begin errors++; $display("FAIL bp_l2[%0d] got %0d expected %0d", j, cap[0][j], e0); end
      checks++; if (cap[1][j] !== e1) begin errors++; $display("FAIL bp_l1[%0d] got %0d expected %0d", j, cap[1][j], e1); end
      checks++; if (cap[2][j] !== e2) begin errors++; $display("FAIL bp_clip[%0d] got %0d expected %0d", j, cap[2][j], e2); end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int cyc;
    for (int j = 0; j < 36; j++) stim[j] = 16'd100;
    clear_mon; drive(36);
    cyc = 0;
    while (ncap[0] < 3 && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (cyc >= 4000) begin errors++; $display("FAIL rstmid_reach got ncap=%0d expected 3", ncap[0]); end
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (ov !== 3'b000) begin errors++; $display("FAIL rstmid_valid got %b expected 000", ov); end
    checks++; if (in_rdy !== 3'b111) begin errors++; $display("FAIL rstmid_in_ready got %b expected 111", in_rdy); end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_mon; drive(36); wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout got ncap=%0d expected 36", ncap[0]); end
    checks++; if (ncap[0] !== 36 || ndone[0] !== 1) begin errors++; $display("FAIL rstmid_count got %0d/%0d expected 36/1", ncap[0], ndone[0]); end
    for (int j = 0; j < 36; j++) begin
      checks++; if (cap[0][j] !== 16'd5461) begin errors++; $display("FAIL rstmid_l2[%0d] got %0d expected 5461", j, cap[0][j]); end
    end
  endtask

  task automatic test_resync;
    bit ok;
    for (int j = 0; j < 36; j++) stim[j] = 16'd777;
    clear_mon; drive(10);
    for (int j = 0; j < 36; j++) stim[j] = 16'd100;
    drive(36); wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL resync_timeout got ncap=%0d expected 36", ncap[0]); end
    checks++; if (nsync[0] !== 1) begin errors++; $display("FAIL resync_pulse got %0d expected 1", nsync[0]); end
    checks++; if (ncap[0] !== 36) begin errors++; $display("FAIL resync_count got %0d expected 36", ncap[0]); end
    for (int j = 0; j < 36; j++) begin
      checks++; if (cap[0][j] !== 16'd5461) begin errors++; $display("FAIL resync_l2[%0d] got %0d expected 5461", j, cap[0][j]); end
      checks++; if (cap[1][j] !== 16'd909) begin errors++; $display("FAIL resync_l1[%0d] got %0d expected 909", j, cap[1][j]); end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_data = '0;
    out_ready = 1'b1; mon_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    test_l2_uniform;
    test_single_peak;
    test_all_zero;
    test_backpressure;
    test_reset_mid;
    test_resync;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
